// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: shares one memory (combinational read port, synchronous write
// port) between the CPU and a Game Boy style OAM DMA engine. A CPU write to
// DMA_REG_ADDR latches the source high byte and copies LEN bytes from
// {src_hi,8'h00} to DST_BASE, one read cycle and one write cycle per byte.
// While the copy runs the CPU is locked out of memory.
//
// Optional build macro OAM_DMA_HRAM_PASS_EN: lets the CPU reach HRAM
// (0xFF80..0xFFFE) during the copy by using whichever memory port the DMA
// leaves free in the current phase; cpu_wait holds the CPU otherwise.
//
// CPU bus handshake: cpu_wait is a combinational hold. When cpu_wait=1 the
// CPU keeps its current access (address/data/enable) unchanged and the access
// is not performed that cycle; when cpu_wait=0 the access completes at the
// next rising edge (writes) or in the same cycle (reads).
//
// The FSM state is the enum signal 'state', kept at module scope so checkers
// can bind to it directly.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] DST_BASE     = 16'hFE00,
  parameter int          LEN          = 160,
  parameter int          START_DELAY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_r_addr,
  output logic [7:0]  cpu_r_data,
  input  logic        cpu_wen,
  input  logic [15:0] cpu_w_addr,
  input  logic [7:0]  cpu_w_data,
  output logic        cpu_wait,
  output logic [15:0] mem_r_addr,
  input  logic [7:0]  mem_r_data,
  output logic        mem_wen,
  output logic [15:0] mem_w_addr,
  output logic [7:0]  mem_w_data,
  output logic        dma_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_RD    = 2'd2,
    S_WR    = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT   = 8'(LEN - 1);
  localparam logic [3:0] DELAY_INIT = 4'(START_DELAY);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] dma_reg;
  logic [7:0] cnt;
  logic [3:0] dly_cnt;
  logic [7:0] data_latch;
  logic       reg_wr;

  // A CPU write to the DMA register starts (or restarts) a transfer.
  assign reg_wr = cpu_wen && (cpu_w_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_HRAM_PASS_EN
  logic hram_r;
  logic hram_w;
  assign hram_r = (cpu_r_addr >= 16'hFF80) && (cpu_r_addr <= 16'hFFFE);
  assign hram_w = cpu_wen && (cpu_w_addr >= 16'hFF80) && (cpu_w_addr <= 16'hFFFE);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a register write overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (reg_wr) begin
      state_nxt = (START_DELAY == 0) ? S_RD : S_DELAY;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_DELAY: if (dly_cnt <= 4'd1) state_nxt = S_RD;
        S_RD:    state_nxt = S_WR;
        S_WR:    state_nxt = (cnt == LAST_CNT) ? S_IDLE : S_RD;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath registers: source byte, byte/delay counters and the read latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dma_reg    <= 8'h00;
      cnt        <= 8'h00;
      dly_cnt    <= 4'h0;
      data_latch <= 8'h00;
    end else begin
      if (state == S_RD) data_latch <= mem_r_data;
      if (reg_wr) begin
        dma_reg <= cpu_w_data;
        cnt     <= 8'h00;
        dly_cnt <= DELAY_INIT;
      end else begin
        if (state == S_DELAY) dly_cnt <= dly_cnt - 4'd1;
        if (state == S_WR && cnt != LAST_CNT) cnt <= cnt + 8'd1;
      end
    end
  end

  // Output and port-steering logic per state.
  always_comb begin
    dma_busy   = (state != S_IDLE);
    cpu_wait   = 1'b0;
    mem_r_addr = cpu_r_addr;
    cpu_r_data = mem_r_data;
    mem_wen    = 1'b0;
    mem_w_addr = cpu_w_addr;
    mem_w_data = cpu_w_data;
    case (state)
      S_IDLE, S_DELAY: begin
        mem_wen = cpu_wen && !reg_wr;
      end
      S_RD: begin
        mem_r_addr = {dma_reg, cnt};
        cpu_r_data = 8'hFF;
`ifdef OAM_DMA_HRAM_PASS_EN
        // Write port is free in RD: HRAM writes go through, HRAM reads wait.
        if (hram_w) mem_wen = 1'b1;
        if (hram_r) cpu_wait = 1'b1;
`endif
      end
      S_WR: begin
        mem_wen    = 1'b1;
        mem_w_addr = DST_BASE + {8'h00, cnt};
        mem_w_data = data_latch;
        cpu_r_data = 8'hFF;
`ifdef OAM_DMA_HRAM_PASS_EN
        // Read port is free in WR: HRAM reads go through, HRAM writes wait.
        if (hram_r) begin
          mem_r_addr = cpu_r_addr;
          cpu_r_data = mem_r_data;
        end
        if (hram_w) cpu_wait = 1'b1;
`endif
      end
      default: begin
        mem_wen = 1'b0;
      end
    endcase
    // The DMA register is readable in every state without the memory port.
    if (cpu_r_addr == DMA_REG_ADDR) cpu_r_data = dma_reg;
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed tests for oam_dma_ctrl with a behavioural memory.
// u_dut runs the default parameters; u_dut1 runs START_DELAY=0, LEN=1.
module tb_oam_dma_ctrl;

  logic        clk;
  logic        rst_n;

  logic [15:0] cpu_r_addr;
  logic [7:0]  cpu_r_data;
  logic        cpu_wen;
  logic [15:0] cpu_w_addr;
  logic [7:0]  cpu_w_data;
  logic        cpu_wait;
  logic [15:0] mem_r_addr;
  logic [7:0]  mem_r_data;
  logic        mem_wen;
  logic [15:0] mem_w_addr;
  logic [7:0]  mem_w_data;
  logic        dma_busy;

  logic [15:0] c1_r_addr;
  logic [7:0]  c1_r_data;
  logic        c1_wen;
  logic [15:0] c1_w_addr;
  logic [7:0]  c1_w_data;
  logic        c1_wait;
  logic [15:0] m1_r_addr;
  logic [7:0]  m1_r_data;
  logic        m1_wen;
  logic [15:0] m1_w_addr;
  logic [7:0]  m1_w_data;
  logic        c1_busy;

  logic [7:0] mem  [0:65535];
  logic [7:0] mem1 [0:65535];

  int checks;
  int failures;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  oam_dma_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_r_addr(cpu_r_addr), .cpu_r_data(cpu_r_data),
    .cpu_wen(cpu_wen), .cpu_w_addr(cpu_w_addr), .cpu_w_data(cpu_w_data),
    .cpu_wait(cpu_wait),
    .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_wen(mem_wen), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .dma_busy(dma_busy)
  );

  oam_dma_ctrl #(.START_DELAY(0), .LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_r_addr(c1_r_addr), .cpu_r_data(c1_r_data),
    .cpu_wen(c1_wen), .cpu_w_addr(c1_w_addr), .cpu_w_data(c1_w_data),
    .cpu_wait(c1_wait),
    .mem_r_addr(m1_r_addr), .mem_r_data(m1_r_data),
    .mem_wen(m1_wen), .mem_w_addr(m1_w_addr), .mem_w_data(m1_w_data),
    .dma_busy(c1_busy)
  );

  // Behavioural memories: combinational read, write at the rising edge.
  assign mem_r_data = mem[mem_r_addr];
  assign m1_r_data  = mem1[m1_r_addr];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_w_addr] = mem_w_data;
    if (m1_wen)  mem1[m1_w_addr] = m1_w_data;
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_wen    = 1'b1;
    cpu_w_addr = a;
    cpu_w_data = d;
    @(negedge clk);
    cpu_wen    = 1'b0;
  endtask

  // Called at a negedge right after a register write; counts busy cycles.
  task automatic measure_busy(output int n);
    n = 0;
    #1;
    while (dma_busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (dma_busy !== 1'b0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (dma_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout: dma_busy=%b after %0d cycles, need 0", name, dma_busy, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cpu_r_addr = 16'hFF46;
    #1;
    checks++;
    if (dma_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b need 0", dma_busy); end
    checks++;
    if (mem_wen !== 1'b0) begin failures++; $display("FAIL reset_wen: got %b need 0", mem_wen); end
    checks++;
    if (cpu_wait !== 1'b0) begin failures++; $display("FAIL reset_wait: got %b need 0", cpu_wait); end
    checks++;
    if (cpu_r_data !== 8'h00) begin failures++; $display("FAIL reset_dma_reg: got %h need 00", cpu_r_data); end
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    cpu_r_addr = 16'hC005;
    cpu_wen    = 1'b1;
    cpu_w_addr = 16'hA000;
    cpu_w_data = 8'h3A;
    #1;
    checks++;
    if (cpu_r_data !== 8'h05) begin failures++; $display("FAIL pass_read: got %h need 05", cpu_r_data); end
    checks++;
    if (mem_wen !== 1'b1) begin failures++; $display("FAIL pass_wen: got %b need 1", mem_wen); end
    @(negedge clk);
    cpu_wen = 1'b0;
    checks++;
    if (mem[16'hA000] !== 8'h3A) begin failures++; $display("FAIL pass_write: got %h need 3a", mem[16'hA000]); end
  endtask

  task automatic test_basic_copy;
    int n;
    @(negedge clk);
    cpu_wen    = 1'b1;
    cpu_w_addr = 16'hFF46;
    cpu_w_data = 8'hC0;
    #1;
    checks++;
    if (mem_wen !== 1'b0) begin failures++; $display("FAIL reg_not_forwarded: mem_wen=%b need 0", mem_wen); end
    @(negedge clk);
    cpu_wen = 1'b0;
    measure_busy(n);
    checks++;
    if (n != 321) begin failures++; $display("FAIL basic_busy_cycles: got %0d need 321", n); end
    for (int i = 0; i < 160; i++) begin
      checks++;
      if (mem[16'hFE00 + 16'(i)] !== 8'(i)) begin
        failures++;
        $display("FAIL basic_oam[%0d]: got %h need %h", i, mem[16'hFE00 + 16'(i)], 8'(i));
      end
    end
    checks++;
    if (mem[16'hFF46] !== 8'h77) begin failures++; $display("FAIL reg_mem_untouched: got %h need 77", mem[16'hFF46]); end
    cpu_r_addr = 16'hFF46;
    #1;
    checks++;
    if (cpu_r_data !== 8'hC0) begin failures++; $display("FAIL basic_readback: got %h need c0", cpu_r_data); end
  endtask

  task automatic test_blocking;
    cpu_write(16'hFF46, 8'hC0);
    repeat (5) @(negedge clk);
    cpu_r_addr = 16'hC010;
    #1;
    checks++;
    if (cpu_r_data !== 8'hFF) begin failures++; $display("FAIL block_read: got %h need ff", cpu_r_data); end
    cpu_write(16'hC020, 8'h55);
    checks++;
    if (mem[16'hC020] !== 8'h20) begin failures++; $display("FAIL block_write_dropped: got %h need 20", mem[16'hC020]); end
    wait_idle("block");
    cpu_write(16'hC020, 8'h55);
    checks++;
    if (mem[16'hC020] !== 8'h55) begin failures++; $display("FAIL idle_write_lands: got %h need 55", mem[16'hC020]); end
    mem[16'hC020] = 8'h20;
  endtask

  task automatic test_restart;
    int n;
    cpu_write(16'hFF46, 8'hC0);
    repeat (100) @(negedge clk);
    cpu_write(16'hFF46, 8'hD0);
    measure_busy(n);
    checks++;
    if (n != 321) begin failures++; $display("FAIL restart_busy_cycles: got %0d need 321", n); end
    for (int i = 0; i < 160; i++) begin
      checks++;
      if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'hA5)) begin
        failures++;
        $display("FAIL restart_oam[%0d]: got %h need %h", i, mem[16'hFE00 + 16'(i)], 8'(i) ^ 8'hA5);
      end
    end
  endtask

  task automatic test_same_cycle_read;
    @(negedge clk);
    cpu_r_addr = 16'hFF46;
    cpu_wen    = 1'b1;
    cpu_w_addr = 16'hFF46;
    cpu_w_data = 8'h12;
    #1;
    checks++;
    if (cpu_r_data !== 8'hD0) begin failures++; $display("FAIL same_cycle_old: got %h need d0", cpu_r_data); end
    @(negedge clk);
    cpu_wen = 1'b0;
    #1;
    checks++;
    if (cpu_r_data !== 8'h12) begin failures++; $display("FAIL same_cycle_new: got %h need 12", cpu_r_data); end
    wait_idle("same_cycle");
  endtask

  task automatic test_hram;
    mem[16'hFF90] = 8'h5A;
    mem[16'hFF91] = 8'h11;
    cpu_write(16'hFF46, 8'hC0);
    // Now in DELAY; next negedge is RD of byte 0, then WR, RD, ...
    cpu_r_addr = 16'hFF90;
`ifdef OAM_DMA_HRAM_PASS_EN
    @(negedge clk); #1;  // RD
    checks++;
    if (cpu_wait !== 1'b1) begin failures++; $display("FAIL hram_rd_wait: got %b need 1", cpu_wait); end
    @(negedge clk); #1;  // WR
    checks++;
    if (cpu_wait !== 1'b0) begin failures++; $display("FAIL hram_rd_release: got %b need 0", cpu_wait); end
    checks++;
    if (cpu_r_data !== 8'h5A) begin failures++; $display("FAIL hram_rd_data: got %h need 5a", cpu_r_data); end
    @(negedge clk);      // RD
    cpu_r_addr = 16'h0000;
    @(negedge clk);      // WR
    cpu_wen = 1'b1; cpu_w_addr = 16'hFF91; cpu_w_data = 8'h66;
    #1;
    checks++;
    if (cpu_wait !== 1'b1) begin failures++; $display("FAIL hram_wr_wait: got %b need 1", cpu_wait); end
    @(negedge clk); #1;  // RD, write performed at next edge
    checks++;
    if (cpu_wait !== 1'b0) begin failures++; $display("FAIL hram_wr_release: got %b need 0", cpu_wait); end
    @(negedge clk);      // WR
    cpu_w_addr = 16'hC000; cpu_w_data = 8'h99;
    #1;
    checks++;
    if (mem[16'hFF91] !== 8'h66) begin failures++; $display("FAIL hram_wr_data: got %h need 66", mem[16'hFF91]); end
    checks++;
    if (cpu_wait !== 1'b0) begin failures++; $display("FAIL nonhram_wait: got %b need 0", cpu_wait); end
    @(negedge clk);      // RD: still non-HRAM, must be dropped
    @(negedge clk);
    cpu_wen = 1'b0;
    checks++;
    if (mem[16'hC000] !== 8'h00) begin failures++; $display("FAIL nonhram_dropped: got %h need 00", mem[16'hC000]); end
`else
    @(negedge clk); #1;  // RD
    checks++;
    if (cpu_wait !== 1'b0) begin failures++; $display("FAIL hram_base_wait: got %b need 0", cpu_wait); end
    checks++;
    if (cpu_r_data !== 8'hFF) begin failures++; $display("FAIL hram_base_rd: got %h need ff", cpu_r_data); end
    @(negedge clk);      // WR
    cpu_wen = 1'b1; cpu_w_addr = 16'hFF91; cpu_w_data = 8'h66;
    #1;
    checks++;
    if (cpu_r_data !== 8'hFF) begin failures++; $display("FAIL hram_base_rd_wr: got %h need ff", cpu_r_data); end
    @(negedge clk);      // RD
    @(negedge clk);
    cpu_wen = 1'b0;
    checks++;
    if (mem[16'hFF91] !== 8'h11) begin failures++; $display("FAIL hram_base_wr_dropped: got %h need 11", mem[16'hFF91]); end
`endif
    wait_idle("hram");
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = 8'hEE;
    cpu_write(16'hFF46, 8'hC0);
    repeat (161) @(negedge clk);  // RD of byte 80
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cpu_r_addr = 16'hFF46;
    #1;
    checks++;
    if (dma_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b need 0", dma_busy); end
    checks++;
    if (mem_wen !== 1'b0) begin failures++; $display("FAIL midrst_wen: got %b need 0", mem_wen); end
    checks++;
    if (cpu_r_data !== 8'h00) begin failures++; $display("FAIL midrst_dma_reg: got %h need 00", cpu_r_data); end
    repeat (400) @(negedge clk);
    checks++;
    if (mem[16'hFE4F] !== 8'h4F) begin failures++; $display("FAIL midrst_byte79: got %h need 4f", mem[16'hFE4F]); end
    for (int i = 80; i < 160; i++) begin
      checks++;
      if (mem[16'hFE00 + 16'(i)] !== 8'hEE) begin
        failures++;
        $display("FAIL midrst_oam[%0d]: got %h need ee", i, mem[16'hFE00 + 16'(i)]);
      end
    end
  endtask

  task automatic test_len1;
    int n;
    @(negedge clk);
    c1_wen = 1'b1; c1_w_addr = 16'hFF46; c1_w_data = 8'h80;
    @(negedge clk);
    c1_wen = 1'b0;
    n = 0;
    #1;
    while (c1_busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (n != 2) begin failures++; $display("FAIL len1_busy_cycles: got %0d need 2", n); end
    checks++;
    if (mem1[16'hFE00] !== 8'h3C) begin failures++; $display("FAIL len1_data: got %h need 3c", mem1[16'hFE00]); end
    checks++;
    if (mem1[16'hFE01] !== 8'h00) begin failures++; $display("FAIL len1_no_extra: got %h need 00", mem1[16'hFE01]); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    cpu_r_addr = 16'h0000;
    cpu_wen    = 1'b0;
    cpu_w_addr = 16'h0000;
    cpu_w_data = 8'h00;
    c1_r_addr  = 16'h0000;
    c1_wen     = 1'b0;
    c1_w_addr  = 16'h0000;
    c1_w_data  = 8'h00;
    for (int i = 0; i < 65536; i++) begin
      mem[i]  = 8'h00;
      mem1[i] = 8'h00;
    end
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + 16'(i)] = 8'(i);
      mem[16'hD000 + 16'(i)] = 8'(i) ^ 8'hA5;
    end
    mem[16'hFF46]  = 8'h77;
    mem1[16'h8000] = 8'h3C;

    test_reset();
    test_passthrough();
    test_basic_copy();
    test_blocking();
    test_restart();
    test_same_cycle_read();
    test_hram();
    test_mid_reset();
    test_len1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
